// File: rtl/triangle_wire_scanner_if.sv
// Framebuffer write port: one pixel write per req/ack handshake.
// The scanner is the master; wr_x/wr_y/wr_color stay stable while wr_req waits for wr_ack.
interface triangle_wire_scanner_if;
  logic       wr_req;
  logic [8:0] wr_x;
  logic [8:0] wr_y;
  logic [7:0] wr_color;
  logic       wr_ack;

  modport master (output wr_req, wr_x, wr_y, wr_color, input wr_ack);
  modport slave  (input wr_req, wr_x, wr_y, wr_color, output wr_ack);
endinterface

// File: rtl/triangle_wire_scanner.sv
// Walks the clamped bounding box of a triangle in raster order, one pixel per cycle, and issues one write per edge hit.
// A hit stalls the scan in WRITE until wr_ack; start is only honoured while idle.
module triangle_wire_scanner #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic [8:0]  v0x,
  input  logic [8:0]  v0y,
  input  logic [8:0]  v1x,
  input  logic [8:0]  v1y,
  input  logic [8:0]  v2x,
  input  logic [8:0]  v2y,
  input  logic [7:0]  color,
  output logic [8:0]  currx,
  output logic [8:0]  curry,
  input  logic        hit,
  output logic [8:0]  tv0x,
  output logic [8:0]  tv0y,
  output logic [8:0]  tv1x,
  output logic [8:0]  tv1y,
  output logic [8:0]  tv2x,
  output logic [8:0]  tv2y,
  output logic        busy,
  output logic        done,
  output logic [18:0] pixels_written,
  triangle_wire_scanner_if.master fb
);

  localparam logic [8:0] X_LAST = 9'(SCREEN_W - 1);
  localparam logic [8:0] Y_LAST = 9'(SCREEN_H - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SCAN, WRITE, DONE} state_t;
  state_t state, state_nxt;

  logic [7:0] color_q;
  logic [8:0] xmin_q, xmax_q, ymax_q;
  logic [8:0] xmin_c, xmax_c, ymin_c, ymax_c;
  logic [8:0] adv_x, adv_y;
  logic       off_screen, last;

  always_comb begin
    xmin_c = tv0x;
    xmax_c = tv0x;
    ymin_c = tv0y;
    ymax_c = tv0y;
    if (tv1x < xmin_c) xmin_c = tv1x;
    if (tv2x < xmin_c) xmin_c = tv2x;
    if (tv1x > xmax_c) xmax_c = tv1x;
    if (tv2x > xmax_c) xmax_c = tv2x;
    if (tv1y < ymin_c) ymin_c = tv1y;
    if (tv2y < ymin_c) ymin_c = tv2y;
    if (tv1y > ymax_c) ymax_c = tv1y;
    if (tv2y > ymax_c) ymax_c = tv2y;
    if (xmax_c > X_LAST) xmax_c = X_LAST;
    if (ymax_c > Y_LAST) ymax_c = Y_LAST;
  end

  assign off_screen = (xmin_c > X_LAST) || (ymin_c > Y_LAST);
  assign last       = (currx == xmax_q) && (curry == ymax_q);
  // End of row wraps to xmin on the next row; never evaluated past the last pixel.
  assign adv_x      = (currx == xmax_q) ? xmin_q : currx + 9'd1;
  assign adv_y      = (currx == xmax_q) ? curry + 9'd1 : curry;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   state_nxt = off_screen ? DONE : SCAN;
      SCAN:    if (hit) state_nxt = WRITE;
               else if (last) state_nxt = DONE;
      WRITE:   if (fb.wr_ack) state_nxt = last ? DONE : SCAN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tv0x <= '0; tv0y <= '0; tv1x <= '0; tv1y <= '0; tv2x <= '0; tv2y <= '0;
      color_q        <= '0;
      xmin_q         <= '0;
      xmax_q         <= '0;
      ymax_q         <= '0;
      currx          <= '0;
      curry          <= '0;
      fb.wr_req      <= 1'b0;
      fb.wr_x        <= '0;
      fb.wr_y        <= '0;
      fb.wr_color    <= '0;
      pixels_written <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          tv0x <= v0x; tv0y <= v0y; tv1x <= v1x; tv1y <= v1y; tv2x <= v2x; tv2y <= v2y;
          color_q        <= color;
          pixels_written <= '0;
        end
        SETUP: if (!off_screen) begin
          xmin_q <= xmin_c;
          xmax_q <= xmax_c;
          ymax_q <= ymax_c;
          currx  <= xmin_c;
          curry  <= ymin_c;
        end
        SCAN: begin
          if (hit) begin
            fb.wr_req   <= 1'b1;
            fb.wr_x     <= currx;
            fb.wr_y     <= curry;
            fb.wr_color <= color_q;
          end else if (!last) begin
            currx <= adv_x;
            curry <= adv_y;
          end
        end
        WRITE: if (fb.wr_ack) begin
          fb.wr_req      <= 1'b0;
          pixels_written <= pixels_written + 19'd1;
          if (!last) begin
            currx <= adv_x;
            curry <= adv_y;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_wire_scanner.sv
module tb_triangle_wire_scanner;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int ACK_DLY  = 3;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  v0x = '0, v0y = '0, v1x = '0, v1y = '0, v2x = '0, v2y = '0;
  logic [7:0]  color = '0;
  logic [8:0]  currx, curry;
  logic        hit;
  logic [8:0]  tv0x, tv0y, tv1x, tv1y, tv2x, tv2y;
  logic        busy, done;
  logic [18:0] pixels_written;

  triangle_wire_scanner_if fb ();

  triangle_wire_scanner #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start),
    .v0x(v0x), .v0y(v0y), .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y),
    .color(color), .currx(currx), .curry(curry), .hit(hit),
    .tv0x(tv0x), .tv0y(tv0y), .tv1x(tv1x), .tv1y(tv1y), .tv2x(tv2x), .tv2y(tv2y),
    .busy(busy), .done(done), .pixels_written(pixels_written), .fb(fb)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Point-on-segment test: zero cross product and inside the segment's extent.
  function automatic bit on_seg(input int px, py, ax, ay, bx, by);
    int cr;
    cr = (bx - ax) * (py - ay) - (by - ay) * (px - ax);
    return (cr == 0) &&
           (px >= ((ax < bx) ? ax : bx)) && (px <= ((ax > bx) ? ax : bx)) &&
           (py >= ((ay < by) ? ay : by)) && (py <= ((ay > by) ? ay : by));
  endfunction

  function automatic bit edge_hit(input int px, py, x0, y0, x1, y1, x2, y2);
    return on_seg(px, py, x0, y0, x1, y1) || on_seg(px, py, x1, y1, x2, y2) ||
           on_seg(px, py, x2, y2, x0, y0);
  endfunction

  assign hit = edge_hit(int'(currx), int'(curry), int'(tv0x), int'(tv0y),
                        int'(tv1x), int'(tv1y), int'(tv2x), int'(tv2y));

  // Framebuffer slave: immediate ack, or ack after ACK_DLY waiting cycles.
  bit ack_delayed = 1'b0;
  int wait_cnt = 0;
  always @(posedge Clk) begin
    #2;
    if (!Reset_n) begin
      fb.wr_ack = 1'b0;
      wait_cnt  = 0;
    end else if (!ack_delayed) begin
      fb.wr_ack = 1'b1;
    end else if (fb.wr_req) begin
      if (wait_cnt == ACK_DLY) begin
        fb.wr_ack = 1'b1;
        wait_cnt  = 0;
      end else begin
        fb.wr_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      fb.wr_ack = 1'b0;
      wait_cnt  = 0;
    end
  end

  logic [25:0] wr_q[$];
  logic [25:0] exp_q[$];
  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [25:0] prev_dat = '0;

  always @(negedge Clk) begin
    if (fb.wr_req && prev_req && !prev_ack)
      check("wr_hold_stable", 32'({fb.wr_x, fb.wr_y, fb.wr_color}), 32'(prev_dat));
    if (prev_req && prev_ack)
      check("wr_req_drop_after_ack", 32'(fb.wr_req), 32'd0);
    if (fb.wr_req && fb.wr_ack) begin
      wr_q.push_back({fb.wr_x, fb.wr_y, fb.wr_color});
      check("wr_x_on_screen", 32'(fb.wr_x <= 9'(SCREEN_W - 1)), 32'd1);
    end
    prev_req = fb.wr_req;
    prev_ack = fb.wr_ack;
    prev_dat = {fb.wr_x, fb.wr_y, fb.wr_color};
  end

  task automatic build_expected(input int ax, ay, bx, by, cx, cy, input logic [7:0] col);
    exp_q.delete();
    for (int y = 0; y < SCREEN_H; y++)
      for (int x = 0; x < SCREEN_W; x++)
        if (edge_hit(x, y, ax, ay, bx, by, cx, cy))
          exp_q.push_back({9'(x), 9'(y), col});
  endtask

  task automatic run_job(input string name, input int ax, ay, bx, by, cx, cy,
                         input logic [7:0] col, input bit mid, input int exp_cycles);
    int  cycles;
    bit  got;
    int  n;
    build_expected(ax, ay, bx, by, cx, cy, col);
    wr_q.delete();
    @(negedge Clk);
    v0x = 9'(ax); v0y = 9'(ay); v1x = 9'(bx); v1y = 9'(by); v2x = 9'(cx); v2y = 9'(cy);
    color = col;
    start = 1'b1;
    @(posedge Clk); #1;
    start  = 1'b0;
    cycles = 1;
    check({name, "_busy_on_start"}, 32'(busy), 32'd1);
    check({name, "_count_cleared"}, 32'(pixels_written), 32'd0);
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        @(posedge Clk); #1;
        cycles++;
        if (mid && cycles == 5) begin
          start = 1'b1;
          v0x = 9'd100; v0y = 9'd100; v1x = 9'd120; v1y = 9'd100; v2x = 9'd100; v2y = 9'd130;
          color = 8'hEE;
        end else start = 1'b0;
      end
    end
    check({name, "_done_seen"}, 32'(got), 32'd1);
    if (exp_cycles >= 0) check({name, "_job_cycles"}, 32'(cycles), 32'(exp_cycles));
    @(posedge Clk); #1;
    check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    check({name, "_idle_after"}, 32'(busy), 32'd0);
    check({name, "_pixels_written"}, 32'(pixels_written), 32'(exp_q.size()));
    check({name, "_write_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_write%0d", name, i), 32'(wr_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    bit found;
    #1;
    check("rst_currx", 32'(currx), 32'd0);
    check("rst_curry", 32'(curry), 32'd0);
    check("rst_wr", 32'({fb.wr_x, fb.wr_y, fb.wr_color}), 32'd0);
    check("rst_wr_req", 32'(fb.wr_req), 32'd0);
    check("rst_busy_done", 32'({busy, done}), 32'd0);
    check("rst_pixels", 32'(pixels_written), 32'd0);
    check("rst_tv", 32'({tv0x, tv0y, tv2y}), 32'd0);
    #12 Reset_n = 1'b1;

    run_job("single", 10, 10, 10, 10, 10, 10, 8'h5A, 1'b0, 4);
    check("single_one_write", 32'(exp_q.size()), 32'd1);
    run_job("tri_fast", 0, 0, 4, 0, 0, 4, 8'h33, 1'b0, 39);
    ack_delayed = 1'b1;
    run_job("tri_slow", 0, 0, 4, 0, 0, 4, 8'h44, 1'b0, -1);
    ack_delayed = 1'b0;
    run_job("offscreen", 400, 250, 450, 260, 420, 300, 8'h11, 1'b0, 2);
    run_job("clamp", 310, 0, 330, 5, 315, 5, 8'h77, 1'b0, -1);
    run_job("mid_start", 0, 0, 4, 0, 0, 4, 8'h99, 1'b1, 39);
    check("mid_start_tv0x", 32'(tv0x), 32'd0);
    check("mid_start_tv1x", 32'(tv1x), 32'd4);

    // Abort a job while its first write is waiting for ack.
    ack_delayed = 1'b1;
    @(negedge Clk);
    v0x = 9'd0; v0y = 9'd0; v1x = 9'd4; v1y = 9'd0; v2x = 9'd0; v2y = 9'd4;
    color = 8'hC3;
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (fb.wr_req) found = 1'b1;
      else begin @(posedge Clk); #1; end
    end
    check("abort_reached_write", 32'(found), 32'd1);
    @(negedge Clk); #2;
    Reset_n = 1'b0;
    #1;
    check("abort_wr_req", 32'(fb.wr_req), 32'd0);
    check("abort_busy_done", 32'({busy, done}), 32'd0);
    check("abort_pixels", 32'(pixels_written), 32'd0);
    #10 Reset_n = 1'b1;
    run_job("after_abort", 0, 0, 4, 0, 0, 4, 8'hC3, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/triangle_wire_scanner.md
# triangle_wire_scanner

Sequencer for the wireframe triangle edge-test datapath. It latches three vertices and a colour, walks every pixel of the triangle's screen-clamped bounding box in raster order and drives each coordinate into the edge-test datapath. For each pixel the datapath reports on the edge, it issues one framebuffer write through a req/ack handshake. It sits between the scene/command logic, which starts the block, and the framebuffer write port.

## Interface
Parameters:
- SCREEN_W, 320, visible width in pixels; x range 0..SCREEN_W-1, must be ≤ 512
- SCREEN_H, 240, visible height in pixels; y range 0..SCREEN_H-1, must be ≤ 512

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- v0x, v0y, v1x, v1y, v2x, v2y  in  9 each  vertex coordinates, latched when start is accepted
- color  in  8  pixel colour, latched when start is accepted
- currx, curry  out  9 each  coordinate currently under test, to the edge-test datapath
- hit  in  1  combinational edge-test result for (currx, curry)
- tv0x..tv2y  out  9 each  latched vertices, to the edge-test datapath
- wr_req  out  1  framebuffer write request
- wr_x, wr_y  out  9 each  write address
- wr_color  out  8  write data
- wr_ack  in  1  write accepted; meaningful only while wr_req=1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on job completion
- pixels_written  out  19  count of completed writes in the current or last job

## Operation
- States: IDLE, SETUP, SCAN, WRITE, DONE.
- IDLE:
  - On start=1, latch vertices and colour, clear pixels_written, then go to SETUP.
  - start outside IDLE is ignored; it is neither queued nor able to restart a job.
- SETUP (one cycle):
  - xmin/xmax = min/max of v0x, v1x, v2x; ymin/ymax likewise for y.
  - Clamp xmax to SCREEN_W-1 and ymax to SCREEN_H-1.
  - If xmin > SCREEN_W-1 or ymin > SCREEN_H-1, the box is fully off-screen: go to DONE.
  - Otherwise set currx=xmin, curry=ymin and go to SCAN.
- SCAN: hit is evaluated each cycle for (currx, curry).
  - hit=1: copy currx/curry/colour into wr_x/wr_y/wr_color, assert wr_req, go to WRITE. The position is not advanced yet.
  - hit=0 and the position is last (currx=xmax and curry=ymax): go to DONE.
  - hit=0 otherwise: advance and stay in SCAN.
- Advance rule: if currx=xmax, set currx=xmin and curry+1; otherwise currx+1. No wrap beyond ymax.
- WRITE:
  - Hold wr_req=1 and stable wr_x/wr_y/wr_color until a cycle with wr_ack=1.
  - In that cycle: increment pixels_written and drop wr_req. Go to DONE if the position was last; otherwise advance and return to SCAN.
- DONE: done=1 for exactly one cycle, then IDLE. pixels_written holds its value until the next accepted start.
- Degenerate triangles (collinear or coincident vertices) need no special handling. The bounding box may be a single pixel, row or column.
- Arithmetic is unsigned 9-bit. The advance never exceeds xmax or ymax, so no overflow occurs.
- Reset_n low at any time, mid-job included, forces IDLE immediately. An in-flight write is abandoned (wr_req drops asynchronously) and is not counted.

## Timing
- Reset values: state=IDLE; currx, curry, wr_x, wr_y = 0; wr_color = 0; tv* = 0; wr_req, busy, done = 0; pixels_written = 0.
- start accepted at edge k: busy=1 from k; SETUP during cycle k..k+1; first SCAN cycle starts at edge k+1.
- Scan throughput: one miss pixel per cycle.
- Hit cost: one SCAN cycle plus ≥1 WRITE cycle. With wr_ack tied high, each hit costs exactly 2 cycles.
- Job cycles with wr_ack tied high: 1 (SETUP) + box pixels + hits + 1 (DONE).
- done is high for the single cycle in DONE; busy falls at the edge returning to IDLE.
- wr_req rises on the edge leaving SCAN and falls on the edge after the wr_ack cycle. There are never two consecutive wr_req cycles for the same pixel after an ack.
- currx/curry change only on advance, so they are stable for the whole WRITE wait.

## Test plan
- Coincident vertices (10,10)×3, wr_ack=1, hit driven by a real edge-test model: exactly one write at (10,10); done in the 4th cycle after start; pixels_written=1.
- Triangle (0,0),(4,0),(0,4), wr_ack=1: 25 pixels scanned in raster order; writes match the edge-test model exactly; pixels_written equals the model hit count; total job cycles = 27 + hits.
- Same triangle with wr_ack delayed 3 cycles per request: wr_req and wr_x/wr_y/wr_color stay stable until ack; same write sequence; no duplicate writes.
- Vertices (400,250),(450,260),(420,300) with SCREEN_W=320: off-screen, so done follows SETUP directly, with zero writes and pixels_written=0. Vertices (310,0),(330,5),(315,5): no write has wr_x > 319.
- start pulsed again mid-job: ignored; the job completes unchanged.
- Reset_n pulsed low during WRITE: wr_req, busy and done drop immediately; state is IDLE. A fresh start then runs a full job from pixels_written=0.
